// File: rtl/tl_mmio_bus_bridge.sv
// Bridges uncached TileLink outer acquires (Get/GetBlock/Put/PutBlock) onto a single-beat 64-bit
// register bus, returning grants tagged with the client xact id. One transaction in flight.
module tl_mmio_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acq_valid,
    output logic        acq_ready,
    input  logic [25:0] acq_addr_block,
    input  logic [1:0]  acq_client_xact_id,
    input  logic [2:0]  acq_addr_beat,
    input  logic        acq_is_builtin_type,
    input  logic [2:0]  acq_a_type,
    input  logic [11:0] acq_union,
    input  logic [63:0] acq_data,
    output logic        gnt_valid,
    input  logic        gnt_ready,
    output logic [2:0]  gnt_addr_beat,
    output logic [1:0]  gnt_client_xact_id,
    output logic        gnt_manager_xact_id,
    output logic        gnt_is_builtin_type,
    output logic [3:0]  gnt_g_type,
    output logic [63:0] gnt_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [63:0] bus_req_wdata,
    output logic [7:0]  bus_req_wmask,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_rdata,
    output logic        err_pulse
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GRANT, S_PUTNEXT} state_t;

    localparam logic [1:0] OP_GET  = 2'd0;
    localparam logic [1:0] OP_GETB = 2'd1;
    localparam logic [1:0] OP_PUT  = 2'd2;
    localparam logic [1:0] OP_PUTB = 2'd3;

    localparam logic [3:0] G_PUT_ACK  = 4'd3;
    localparam logic [3:0] G_GET_BEAT = 4'd4;
    localparam logic [3:0] G_GET_BLK  = 4'd5;

    localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  op_q, op_d;
    logic [25:0] blk_q, blk_d;
    logic [2:0]  beat_q, beat_d;
    logic [7:0]  mask_q, mask_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  timer_q, timer_d;
    logic        acq_ready_q, acq_ready_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic [3:0]  gnt_g_type_q, gnt_g_type_d;
    logic [2:0]  gnt_beat_q, gnt_beat_d;
    logic [63:0] gnt_data_q, gnt_data_d;
    logic        err_q, err_d;

    logic        acq_fire, gnt_fire, timed_out, is_block;
    logic [63:0] resp_data;
    logic        unused_bits;

    assign acq_fire  = acq_valid & acq_ready_q;
    assign gnt_fire  = gnt_valid_q & gnt_ready;
    assign timed_out = TIMEOUT_EN && (timer_q == TIMER_LAST);
    assign is_block  = (op_q == OP_GETB) || (op_q == OP_PUTB);

    // The address byte offset is not used: every access is a full 64-bit word.
    assign unused_bits = ^{acq_union[11:9], acq_union[0]};

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        op_d            = op_q;
        blk_d           = blk_q;
        beat_d          = beat_q;
        mask_d          = mask_q;
        wdata_d         = wdata_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        bus_req_valid_d = bus_req_valid_q;
        gnt_valid_d     = gnt_valid_q;
        gnt_g_type_d    = gnt_g_type_q;
        gnt_beat_d      = gnt_beat_q;
        gnt_data_d      = gnt_data_q;
        err_d           = 1'b0;
        resp_data       = bus_resp_valid ? bus_resp_rdata : 64'h0;

        unique case (state_q)
            S_IDLE: begin
                if (acq_fire) begin
                    id_d    = acq_client_xact_id;
                    op_d    = acq_a_type[1:0];
                    blk_d   = acq_addr_block;
                    beat_d  = acq_addr_beat;
                    mask_d  = acq_union[8:1];
                    wdata_d = acq_data;
                    cnt_d   = 3'd0;
                    if (!acq_is_builtin_type || acq_a_type[2]) begin
                        // Unsupported request: acknowledge without touching the bus.
                        op_d         = OP_PUT;
                        err_d        = 1'b1;
                        state_d      = S_GRANT;
                        gnt_valid_d  = 1'b1;
                        gnt_g_type_d = G_PUT_ACK;
                        gnt_beat_d   = acq_addr_beat;
                        gnt_data_d   = 64'h0;
                    end else begin
                        state_d         = S_REQ;
                        bus_req_valid_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    state_d         = S_WAIT;
                    bus_req_valid_d = 1'b0;
                    timer_d         = 8'd0;
                end
            end
            S_WAIT: begin
                // A timeout completes the access as if zero data had returned.
                if (bus_resp_valid || timed_out) begin
                    err_d = ~bus_resp_valid;
                    unique case (op_q)
                        OP_GET: begin
                            state_d      = S_GRANT;
                            gnt_valid_d  = 1'b1;
                            gnt_g_type_d = G_GET_BEAT;
                            gnt_beat_d   = beat_q;
                            gnt_data_d   = resp_data;
                        end
                        OP_GETB: begin
                            state_d      = S_GRANT;
                            gnt_valid_d  = 1'b1;
                            gnt_g_type_d = G_GET_BLK;
                            gnt_beat_d   = cnt_q;
                            gnt_data_d   = resp_data;
                        end
                        OP_PUT: begin
                            state_d      = S_GRANT;
                            gnt_valid_d  = 1'b1;
                            gnt_g_type_d = G_PUT_ACK;
                            gnt_beat_d   = beat_q;
                            gnt_data_d   = 64'h0;
                        end
                        default: begin
                            if (cnt_q == 3'd7) begin
                                state_d      = S_GRANT;
                                gnt_valid_d  = 1'b1;
                                gnt_g_type_d = G_PUT_ACK;
                                gnt_beat_d   = 3'd0;
                                gnt_data_d   = 64'h0;
                            end else begin
                                state_d = S_PUTNEXT;
                                cnt_d   = cnt_q + 3'd1;
                            end
                        end
                    endcase
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_GRANT: begin
                if (gnt_fire) begin
                    gnt_valid_d = 1'b0;
                    if (op_q == OP_GETB && cnt_q != 3'd7) begin
                        cnt_d           = cnt_q + 3'd1;
                        state_d         = S_REQ;
                        bus_req_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PUTNEXT: begin
                if (acq_fire) begin
                    wdata_d         = acq_data;
                    state_d         = S_REQ;
                    bus_req_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        acq_ready_d = (state_d == S_IDLE) || (state_d == S_PUTNEXT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            id_q            <= 2'd0;
            op_q            <= OP_GET;
            blk_q           <= 26'd0;
            beat_q          <= 3'd0;
            mask_q          <= 8'd0;
            wdata_q         <= 64'h0;
            cnt_q           <= 3'd0;
            timer_q         <= 8'd0;
            acq_ready_q     <= 1'b0;
            bus_req_valid_q <= 1'b0;
            gnt_valid_q     <= 1'b0;
            gnt_g_type_q    <= 4'd0;
            gnt_beat_q      <= 3'd0;
            gnt_data_q      <= 64'h0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            op_q            <= op_d;
            blk_q           <= blk_d;
            beat_q          <= beat_d;
            mask_q          <= mask_d;
            wdata_q         <= wdata_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            acq_ready_q     <= acq_ready_d;
            bus_req_valid_q <= bus_req_valid_d;
            gnt_valid_q     <= gnt_valid_d;
            gnt_g_type_q    <= gnt_g_type_d;
            gnt_beat_q      <= gnt_beat_d;
            gnt_data_q      <= gnt_data_d;
            err_q           <= err_d;
        end
    end

    assign acq_ready           = acq_ready_q;
    assign gnt_valid           = gnt_valid_q;
    assign gnt_addr_beat       = gnt_beat_q;
    assign gnt_client_xact_id  = id_q;
    assign gnt_manager_xact_id = 1'b0;
    assign gnt_is_builtin_type = 1'b1;
    assign gnt_g_type          = gnt_g_type_q;
    assign gnt_data            = gnt_data_q;
    assign bus_req_valid       = bus_req_valid_q;
    assign bus_req_write       = op_q[1];
    assign bus_req_addr        = {blk_q, (is_block ? cnt_q : beat_q), 3'b000};
    assign bus_req_wdata       = wdata_q;
    assign bus_req_wmask       = (op_q == OP_PUT) ? mask_q : 8'hFF;
    assign err_pulse           = err_q;

endmodule
